// File: rtl/cpu_pkg.sv
// Shared CPU definitions: word/address sizes, fetch-state encoding and the
// instruction-word field positions used downstream by the decoder.
package cpu_pkg;

  localparam int INSTR_WIDTH = 16;
  localparam int ADDR_WIDTH  = 4;
  localparam int DEPTH       = 16;

  // Instruction word fields: opcode nibble and increment/target byte.
  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 12;
  localparam int IMM_MSB    = 7;
  localparam int IMM_LSB    = 0;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } fetch_state_e;

  // Opcode field of an instruction word.
  function automatic logic [OPCODE_MSB-OPCODE_LSB:0] get_opcode(input logic [INSTR_WIDTH-1:0] word);
    return word[OPCODE_MSB:OPCODE_LSB];
  endfunction

  // Increment/target byte of an instruction word.
  function automatic logic [IMM_MSB-IMM_LSB:0] get_imm(input logic [INSTR_WIDTH-1:0] word);
    return word[IMM_MSB:IMM_LSB];
  endfunction

endpackage

// File: rtl/program_store.sv
// Program store: DEPTH x INSTR_WIDTH register array with one write port and
// one registered read port. The read register only updates when rd_en is
// high, so it also serves as the instruction register of the fetch stage.
// Ports:
//   clk, rst          clock, async active-high reset (read register only)
//   wr_en/wr_addr/wr_data  write port
//   rd_en/rd_addr     registered read request
//   rd_data           read register contents
module program_store #(
  parameter int INSTR_WIDTH = 16,
  parameter int ADDR_WIDTH  = 4,
  parameter int DEPTH       = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [ADDR_WIDTH-1:0]  wr_addr,
  input  logic [INSTR_WIDTH-1:0] wr_data,
  input  logic                   rd_en,
  input  logic [ADDR_WIDTH-1:0]  rd_addr,
  output logic [INSTR_WIDTH-1:0] rd_data
);

  logic [INSTR_WIDTH-1:0] mem_r [DEPTH];
  logic [INSTR_WIDTH-1:0] rd_data_r;

  // Storage array; deliberately not reset so a program survives rst.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Read register: loads on request, otherwise holds its word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_r <= {INSTR_WIDTH{1'b0}};
    end else if (rd_en) begin
      rd_data_r <= mem_r[rd_addr];
    end else begin
      rd_data_r <= rd_data_r;
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage. After reset the program store is loaded through
// the prog_* port (LOAD); start moves through a one-cycle FILL into RUN,
// where the word at instruction_addr is captured each cycle the IR can
// accept it and offered to the decoder with a valid/ready handshake.
// flush (jump taken) invalidates the IR word and suppresses that capture.
// Ports:
//   clk, rst                 clock, async active-high reset
//   instruction_addr         fetch address from program_counter
//   prog_we/prog_addr/prog_data  store write port, LOAD only
//   start                    ends LOAD
//   flush                    drop current/next word
//   instr_ready              decoder accepts instr_out
//   instr_out/instr_addr_out IR word and the address it came from
//   instr_valid              IR holds a valid word
//   pc_enable                IR can take a new word (combinational)
//   running                  in RUN state
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter int INSTR_WIDTH = 16,
  parameter int ADDR_WIDTH  = 4,
  parameter int DEPTH       = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_WIDTH-1:0]  instruction_addr,
  input  logic                   prog_we,
  input  logic [ADDR_WIDTH-1:0]  prog_addr,
  input  logic [INSTR_WIDTH-1:0] prog_data,
  input  logic                   start,
  input  logic                   flush,
  input  logic                   instr_ready,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic [ADDR_WIDTH-1:0]  instr_addr_out,
  output logic                   instr_valid,
  output logic                   pc_enable,
  output logic                   running
);

  fetch_state_e          state_r;
  fetch_state_e          state_next_s;
  logic                  capture_s;
  logic                  store_we_s;
  logic                  valid_next_s;
  logic                  pc_enable_s;
  logic                  instr_valid_r;
  logic                  running_r;
  logic [ADDR_WIDTH-1:0] instr_addr_r;

  program_store #(
    .INSTR_WIDTH (INSTR_WIDTH),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .DEPTH       (DEPTH)
  ) u_store (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (store_we_s),
    .wr_addr (prog_addr),
    .wr_data (prog_data),
    .rd_en   (capture_s),
    .rd_addr (instruction_addr),
    .rd_data (instr_out)
  );

  // Next-state, capture and write-enable decode.
  always_comb begin
    state_next_s = state_r;
    capture_s    = 1'b0;
    store_we_s   = 1'b0;
    valid_next_s = instr_valid_r;
    pc_enable_s  = 1'b0;
    case (state_r)
      LOAD: begin
        store_we_s   = prog_we;
        valid_next_s = 1'b0;
        if (start) begin
          state_next_s = FILL;
        end else begin
          state_next_s = LOAD;
        end
      end
      FILL: begin
        capture_s    = 1'b1;
        valid_next_s = 1'b1;
        state_next_s = RUN;
      end
      RUN: begin
        pc_enable_s = !instr_valid_r || instr_ready;
        // Flush wins over both capture and stall; IR data is left as is.
        if (flush) begin
          valid_next_s = 1'b0;
        end else if (pc_enable_s) begin
          capture_s    = 1'b1;
          valid_next_s = 1'b1;
        end else begin
          valid_next_s = instr_valid_r;
        end
      end
      default: begin
        state_next_s = LOAD;
        valid_next_s = 1'b0;
      end
    endcase
  end

  // State, valid flag, running flag and fetch-address register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= LOAD;
      instr_valid_r <= 1'b0;
      running_r     <= 1'b0;
      instr_addr_r  <= {ADDR_WIDTH{1'b0}};
    end else begin
      state_r       <= state_next_s;
      instr_valid_r <= valid_next_s;
      running_r     <= (state_next_s == RUN);
      if (capture_s) begin
        instr_addr_r <= instruction_addr;
      end else begin
        instr_addr_r <= instr_addr_r;
      end
    end
  end

  assign instr_addr_out = instr_addr_r;
  assign instr_valid    = instr_valid_r;
  assign pc_enable      = pc_enable_s;
  assign running        = running_r;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch. The driver keeps a behavioural
// model (program array, "word held for the decoder" flag and phase) and
// pushes every word the stage should deliver into exp_q; a separate monitor
// pops and compares on every valid&ready handshake.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  instruction_addr = 4'd0;
  logic        prog_we = 1'b0;
  logic [3:0]  prog_addr = 4'd0;
  logic [15:0] prog_data = 16'd0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic        instr_ready = 1'b0;
  logic [15:0] instr_out;
  logic [3:0]  instr_addr_out;
  logic        instr_valid;
  logic        pc_enable;
  logic        running;

  instruction_fetch dut (
    .clk              (clk),
    .rst              (rst),
    .instruction_addr (instruction_addr),
    .prog_we          (prog_we),
    .prog_addr        (prog_addr),
    .prog_data        (prog_data),
    .start            (start),
    .flush            (flush),
    .instr_ready      (instr_ready),
    .instr_out        (instr_out),
    .instr_addr_out   (instr_addr_out),
    .instr_valid      (instr_valid),
    .pc_enable        (pc_enable),
    .running          (running)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: 0=loading, 1=first fetch pending, 2=running.
  int          m_phase = 0;
  logic [15:0] m_mem [16];
  logic        m_valid = 1'b0;
  logic [15:0] m_word = 16'd0;
  logic [3:0]  m_addr = 4'd0;
  logic [19:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus plus model update for the following edge.
  task automatic step(input logic [3:0] a, input logic rdy, input logic fl,
                      input logic we, input logic [3:0] wa, input logic [15:0] wd,
                      input logic st);
    logic exp_pe;
    @(negedge clk);
    instruction_addr = a;
    instr_ready      = rdy;
    flush            = fl;
    prog_we          = we;
    prog_addr        = wa;
    prog_data        = wd;
    start            = st;
    #1;
    exp_pe = (m_phase == 2) && (!m_valid || rdy);
    chk("pc_enable", {31'd0, pc_enable}, {31'd0, exp_pe});
    chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_valid});
    chk("running", {31'd0, running}, {31'd0, m_phase == 2});
    if (m_valid) begin
      chk("held_word", {16'd0, instr_out}, {16'd0, m_word});
      chk("held_addr", {28'd0, instr_addr_out}, {28'd0, m_addr});
    end
    if (m_phase == 0) begin
      if (we) m_mem[wa] = wd;
      if (st) m_phase = 1;
    end else if (m_phase == 1) begin
      m_word = m_mem[a]; m_addr = a; m_valid = 1'b1;
      exp_q.push_back({a, m_mem[a]});
      m_phase = 2;
    end else begin
      if (fl) begin
        // Held word is lost unless the decoder takes it on this edge.
        if (m_valid && !rdy && exp_q.size() > 0) void'(exp_q.pop_front());
        m_valid = 1'b0;
      end else if (!m_valid || rdy) begin
        m_word = m_mem[a]; m_addr = a; m_valid = 1'b1;
        exp_q.push_back({a, m_mem[a]});
      end
    end
  endtask

  task automatic reset_mid_cycle();
    @(negedge clk);
    prog_we = 1'b0; start = 1'b0; flush = 1'b0; instr_ready = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_running", {31'd0, running}, 32'd0);
    chk("rst_instr_out", {16'd0, instr_out}, 32'd0);
    chk("rst_addr_out", {28'd0, instr_addr_out}, 32'd0);
    exp_q.delete();
    m_valid = 1'b0; m_phase = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: every handshake must deliver the oldest outstanding word.
  initial begin
    logic [19:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && instr_valid && instr_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_transfer", {12'd0, instr_addr_out, instr_out}, 32'hFFFFFFFF);
        end else begin
          e = exp_q.pop_front();
          chk("xfer_word", {16'd0, instr_out}, {16'd0, e[15:0]});
          chk("xfer_addr", {28'd0, instr_addr_out}, {28'd0, e[19:16]});
        end
      end
    end
  end

  initial begin
    logic [15:0] init_words [16];
    for (int i = 0; i < 16; i++) init_words[i] = 16'($urandom);
    init_words[0]  = 16'h1001;
    init_words[1]  = 16'h2002;
    init_words[2]  = 16'h3003;
    init_words[3]  = 16'h4004;
    init_words[15] = 16'hEEEE;

    repeat (2) @(negedge clk);
    #1;
    chk("init_valid", {31'd0, instr_valid}, 32'd0);
    chk("init_running", {31'd0, running}, 32'd0);
    chk("init_instr_out", {16'd0, instr_out}, 32'd0);
    chk("init_addr_out", {28'd0, instr_addr_out}, 32'd0);
    rst = 1'b0;

    // Load the whole store, then start.
    for (int i = 0; i < 16; i++) step(4'd0, 1'b0, 1'b0, 1'b1, 4'(i), init_words[i], 1'b0);
    step(4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0, 1'b1);
    step(4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 16'd0, 1'b0);   // FILL: fetch 0
    step(4'd1, 1'b1, 1'b0, 1'b0, 4'd0, 16'd0, 1'b0);   // IR=2002
    // Stall three cycles with a moving address.
    for (int i = 0; i < 3; i++) step(4'(5 + i), 1'b0, 1'b0, 1'b0, 4'd0, 16'd0, 1'b0);
    step(4'd2, 1'b1, 1'b0, 1'b0, 4'd0, 16'd0, 1'b0);
    step(4'd3, 1'b1, 1'b0, 1'b0, 4'd0, 16'd0, 1'b0);
    // Flush with ready, then capture resumes.
    step(4'd7, 1'b1, 1'b1, 1'b0, 4'd0, 16'd0, 1'b0);
    step(4'd8, 1'b1, 1'b0, 1'b0, 4'd0, 16'd0, 1'b0);
    // Store write attempt in RUN must be ignored.
    step(4'd9, 1'b1, 1'b0, 1'b1, 4'd2, 16'hFFFF, 1'b0);
    step(4'd2, 1'b1, 1'b0, 1'b0, 4'd0, 16'd0, 1'b0);
    // Address wrap 15 -> 0.
    step(4'd15, 1'b1, 1'b0, 1'b0, 4'd0, 16'd0, 1'b0);
    step(4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 16'd0, 1'b0);
    // Flush while stalled drops the held word.
    step(4'd4, 1'b0, 1'b1, 1'b0, 4'd0, 16'd0, 1'b0);
    step(4'd4, 1'b1, 1'b0, 1'b0, 4'd0, 16'd0, 1'b0);
    // Random traffic including ignored writes and stray starts.
    for (int i = 0; i < 300; i++) begin
      step(4'($urandom), ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) == 0),
           $urandom_range(0, 1) == 1, 4'($urandom), 16'($urandom), $urandom_range(0, 9) == 0);
    end

    // Reset mid-run, load mem[3], run a little, reset again.
    step(4'd1, 1'b1, 1'b0, 1'b0, 4'd0, 16'd0, 1'b0);
    reset_mid_cycle();
    step(4'd0, 1'b0, 1'b0, 1'b1, 4'd3, 16'hA5C3, 1'b0);
    step(4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0, 1'b1);
    step(4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 16'd0, 1'b0);
    step(4'd1, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0, 1'b0);
    reset_mid_cycle();
    // Restart without reloading: contents must have survived.
    step(4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0, 1'b1);
    step(4'd3, 1'b1, 1'b0, 1'b0, 4'd0, 16'd0, 1'b0);
    step(4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 16'd0, 1'b0);
    step(4'd15, 1'b1, 1'b0, 1'b0, 4'd0, 16'd0, 1'b0);
    step(4'd15, 1'b1, 1'b0, 1'b0, 4'd0, 16'd0, 1'b0);
    repeat (2) @(negedge clk);
    chk("queue_drained", exp_q.size(), (instr_valid && !instr_ready) ? 32'd1 : 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Stage directly downstream of program_counter.
- Holds the 16-entry program store, which is loaded after reset through a write port.
- Each cycle, reads the word at instruction_addr into an instruction register (IR).
- Presents the IR to the decoder with a valid/ready handshake, and drops the wrong-path word on flush (jump taken).

Parameters:
- INSTR_WIDTH, 16, width of one instruction word.
- ADDR_WIDTH, 4, program-store address width; matches instruction_addr.
- DEPTH, 16, number of program-store entries (2**ADDR_WIDTH).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- instruction_addr  input  ADDR_WIDTH  fetch address from program_counter.
- prog_we  input  1  program-store write strobe; honoured only in LOAD.
- prog_addr  input  ADDR_WIDTH  program-store write address.
- prog_data  input  INSTR_WIDTH  program-store write data.
- start  input  1  single-cycle pulse; ends LOAD.
- flush  input  1  discard the current/next fetched word (jump taken).
- instr_ready  input  1  decoder accepts instr_out this cycle.
- instr_out  output  INSTR_WIDTH  IR contents.
- instr_addr_out  output  ADDR_WIDTH  address the IR word was fetched from.
- instr_valid  output  1  IR holds a valid word.
- pc_enable  output  1  combinational; high when the IR can take a new word. Future PC enable.
- running  output  1  high in RUN state.

Behaviour:
- Reset (async, any state, mid-operation included):
  - state=LOAD; instr_out=0, instr_addr_out=0, instr_valid=0, running=0.
  - Program store contents are NOT cleared.
- State LOAD:
  - prog_we=1 writes prog_data to mem[prog_addr] at the clock edge.
  - instr_valid=0, pc_enable=0.
  - start=1 -> FILL. If prog_we and start are high in the same cycle, the write is performed and the state changes.
- State FILL (exactly one cycle):
  - IR<=mem[instruction_addr], instr_addr_out<=instruction_addr, instr_valid<=1.
  - -> RUN.
- State RUN:
  - running=1; prog_we ignored (no store write).
  - pc_enable = !instr_valid | instr_ready.
  - Capture: if pc_enable and !flush, IR<=mem[instruction_addr], instr_addr_out<=instruction_addr, instr_valid<=1.
  - Stall: if !pc_enable and !flush, IR, instr_addr_out and instr_valid hold (stable data under stall is mandatory).
  - Flush: if flush=1, instr_valid<=0 at that edge and no capture. IR/instr_addr_out keep their old values. Capture resumes next cycle under normal rules. Flush has priority over ready and over stall.
  - start is ignored in RUN. RUN is left only by rst.
- Latency: address to instr_out is one clock (registered read from the store at the capture edge).
- Read-during-write cannot occur, because writes happen only in LOAD.
- Address wrap is owned by program_counter. Every 4-bit address is a legal store index, so there is no out-of-range case.
- Handshake: a transfer occurs on any edge with instr_valid & instr_ready. instr_valid never drops without a transfer or a flush.

Decomposition:
- Shared package (cpu_pkg):
  - INSTR_WIDTH and ADDR_WIDTH constants.
  - fetch state enum {LOAD, FILL, RUN} (2 bits).
  - Field-position constants for the instruction word: opcode [15:12], increment/target byte [7:0], which the decoder feeds to pc_increment.
- Sub-module: program_store, a DEPTH x INSTR_WIDTH register array with write port and registered read-enable port.
- FSM and IR logic remain in instruction_fetch.

Test Plan:
- Reset mid-RUN (rst pulse while instr_valid=1) -> same cycle instr_valid=0, running=0; previously written mem[3]=16'hA5C3 still read back after restart.
- Load mem[0..3]=16'h1001,16'h2002,16'h3003,16'h4004; start; instruction_addr 0,1,2,3 on successive cycles with instr_ready=1 -> instr_out 1001 (FILL+1), then 2002, 3003, 4004; instr_addr_out tracks 0..3.
- RUN, instr_valid=1 with IR=16'h2002, instr_ready=0 for 3 cycles while instruction_addr changes -> instr_out=2002, instr_addr_out=1 and instr_valid=1 held; pc_enable=0.
- RUN, flush=1 for one cycle with instr_ready=1 -> next cycle instr_valid=0, pc_enable=1; following edge captures mem[instruction_addr] with instr_valid=1.
- prog_we=1, prog_addr=2, prog_data=16'hFFFF during RUN -> mem[2] unchanged; a later fetch at address 2 returns 3003.
- Address wrap: instruction_addr 15 then 0, mem[15]=16'hEEEE, mem[0]=16'h1001 -> instr_out EEEE then 1001, with no gap in instr_valid.
